// File: rtl/draw_pkg.sv
// Shared widths, screen limits and box_drawer state encoding.
// Also used by the symbol-drawer datapath so coordinate buses line up.
package draw_pkg;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int SIZE_W   = 5;
  localparam int COLOUR_W = 3;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } box_state_t;
endpackage

// File: rtl/box_scan_counter.sv
// Raster scan counter for one box: cx runs 0..w-1, then cy advances.
// Latency: counters update on the enabled edge; no backpressure, en gates every step.
module box_scan_counter
  import draw_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [SIZE_W-1:0] w_lim,
  input  logic [SIZE_W-1:0] h_lim,
  output logic [SIZE_W-1:0] cx,
  output logic [SIZE_W-1:0] cy,
  output logic              last_col,
  output logic              last
);

  assign last_col = (cx == w_lim - 1'b1);
  assign last     = last_col && (cy == h_lim - 1'b1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cx <= '0;
      cy <= '0;
    end else if (en) begin
      if (last_col) begin
        cx <= '0;
        cy <= cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/box_drawer.sv
// Filled-rectangle pixel engine: one pixel per cycle in raster order, then a one-cycle done.
// Latency: first pixel one cycle after go, done after w*h pixels; go ignored while busy. Optional BOX_DRAWER_OUTLINE_EN.
module box_drawer
  import draw_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
`ifdef BOX_DRAWER_OUTLINE_EN
  input  logic                outline,
`endif
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [SIZE_W-1:0]   width,
  input  logic [SIZE_W-1:0]   height,
  input  logic [COLOUR_W-1:0] colour,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam logic [X_W:0] SCREEN_W_X = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCREEN_H_Y = (Y_W+1)'(SCREEN_H);

  box_state_t state, state_nxt;

  logic [X_W-1:0]      x0_r;
  logic [Y_W-1:0]      y0_r;
  logic [SIZE_W-1:0]   w_r;
  logic [SIZE_W-1:0]   h_r;
  logic [COLOUR_W-1:0] colour_r;
  logic [SIZE_W-1:0]   cx, cy;
  logic                last_col, last;
  logic                accept;
  logic [X_W:0]        sum_x;
  logic [Y_W:0]        sum_y;
  logic                on_screen;
  logic                pix_en;

  assign accept = (state == IDLE) && go;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = ((width == '0) || (height == '0)) ? DONE : DRAW;
      DRAW:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Box parameters are captured only on accept so upstream may move on immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      x0_r     <= '0;
      y0_r     <= '0;
      w_r      <= '0;
      h_r      <= '0;
      colour_r <= '0;
    end else if (accept) begin
      x0_r     <= x0;
      y0_r     <= y0;
      w_r      <= width;
      h_r      <= height;
      colour_r <= colour;
    end
  end

  box_scan_counter u_scan (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .en       (state == DRAW),
    .w_lim    (w_r),
    .h_lim    (h_r),
    .cx       (cx),
    .cy       (cy),
    .last_col (last_col),
    .last     (last)
  );

  // One extra bit keeps off-screen sums from wrapping back into the visible area.
  assign sum_x     = {1'b0, x0_r} + (X_W+1)'(cx);
  assign sum_y     = {1'b0, y0_r} + (Y_W+1)'(cy);
  assign on_screen = (sum_x < SCREEN_W_X) && (sum_y < SCREEN_H_Y);

`ifdef BOX_DRAWER_OUTLINE_EN
  logic outline_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      outline_r <= 1'b0;
    end else if (accept) begin
      outline_r <= outline;
    end
  end

  assign pix_en = !outline_r || (cx == '0) || last_col ||
                  (cy == '0) || (cy == h_r - 1'b1);
`else
  assign pix_en = 1'b1;
`endif

  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    plot       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      DRAW: begin
        vga_x      = sum_x[X_W-1:0];
        vga_y      = sum_y[Y_W-1:0];
        vga_colour = colour_r;
        plot       = on_screen && pix_en;
        busy       = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_box_drawer.sv
// Scoreboarded bench: stimulus queues expected plot/done events with their cycle, monitor pops and compares.
module tb_box_drawer;
  import draw_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                go;
  logic [X_W-1:0]      x0;
  logic [Y_W-1:0]      y0;
  logic [SIZE_W-1:0]   width;
  logic [SIZE_W-1:0]   height;
  logic [COLOUR_W-1:0] colour;
  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                plot;
  logic                busy;
  logic                done;
`ifdef BOX_DRAWER_OUTLINE_EN
  logic                outline;
`endif

  box_drawer dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
`ifdef BOX_DRAWER_OUTLINE_EN
    .outline    (outline),
`endif
    .x0         (x0),
    .y0         (y0),
    .width      (width),
    .height     (height),
    .colour     (colour),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        is_done;
    logic [31:0] cyc;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  col;
  } ev_t;

  ev_t expq[$];
  int  checks = 0;
  int  errors = 0;

  task automatic push_ev(input bit d, input int c, input int x, input int y, input int col);
    ev_t e;
    e.is_done = d;
    e.cyc     = 32'(c);
    e.x       = 8'(x);
    e.y       = 7'(y);
    e.col     = 3'(col);
    expq.push_back(e);
  endtask

  // Reference raster: box accepted at the edge after cycle n; pixel i shows at cycle n+1+i.
  task automatic model_box(input int n, input int bx, input int by, input int w, input int h,
                           input int col, input bit ol);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if ((bx + c) < 160 && (by + r) < 120 &&
            (!ol || c == 0 || c == w - 1 || r == 0 || r == h - 1))
          push_ev(1'b0, n + 1 + r * w + c, bx + c, by + r, col);
      end
    end
    push_ev(1'b1, n + 1 + w * h, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge: present the box, pulse go for one edge, then scramble inputs.
  task automatic start(input int bx, input int by, input int w, input int h, input int col);
    x0     = X_W'(bx);
    y0     = Y_W'(by);
    width  = SIZE_W'(w);
    height = SIZE_W'(h);
    colour = COLOUR_W'(col);
    go     = 1'b1;
    @(negedge clk);
    go     = 1'b0;
    x0     = 8'd77;
    y0     = 7'd33;
    width  = 5'd9;
    height = 5'd9;
    colour = 3'd0;
  endtask

  task automatic busy_window(input int n, input int w, input int h);
    while (cyc <= n + 2 + w * h) begin
      chk("busy", 64'(busy), 64'((cyc >= n + 1) && (cyc <= n + 1 + w * h)));
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    ev_t a, e;
    if (plot === 1'b1 || done === 1'b1) begin
      a.is_done = done;
      a.cyc     = 32'(cyc);
      a.x       = vga_x;
      a.y       = vga_y;
      a.col     = vga_colour;
      checks++;
      if (plot === 1'b1 && done === 1'b1) begin
        errors++;
        $display("FAIL event: plot and done together at cyc %0d", cyc);
      end else if (expq.size() == 0) begin
        errors++;
        $display("FAIL event: unexpected done=%0b x=%0d y=%0d col=%0d at cyc %0d",
                 a.is_done, a.x, a.y, a.col, cyc);
      end else begin
        e = expq.pop_front();
        if (a !== e)
          begin
            errors++;
            $display("FAIL event: got done=%0b cyc=%0d (%0d,%0d) col=%0d expected done=%0b cyc=%0d (%0d,%0d) col=%0d",
                     a.is_done, a.cyc, a.x, a.y, a.col, e.is_done, e.cyc, e.x, e.y, e.col);
          end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset  = 1'b1;
    go     = 1'b0;
    x0     = '0;
    y0     = '0;
    width  = '0;
    height = '0;
    colour = '0;
`ifdef BOX_DRAWER_OUTLINE_EN
    outline = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'({vga_x, vga_y, vga_colour, plot, busy, done}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 2x3 at (10,20), colour 5, hand-listed order
    n = cyc;
    push_ev(1'b0, n + 1, 10, 20, 5);
    push_ev(1'b0, n + 2, 11, 20, 5);
    push_ev(1'b0, n + 3, 10, 21, 5);
    push_ev(1'b0, n + 4, 11, 21, 5);
    push_ev(1'b0, n + 5, 10, 22, 5);
    push_ev(1'b0, n + 6, 11, 22, 5);
    push_ev(1'b1, n + 7, 0, 0, 0);
    start(10, 20, 2, 3, 5);
    busy_window(n, 2, 3);

    // Zero width: done next cycle, idle after
    n = cyc;
    push_ev(1'b1, n + 1, 0, 0, 0);
    start(40, 40, 0, 5, 2);
    busy_window(n, 0, 5);

    // Bottom-right corner clipping, hand-listed
    n = cyc;
    push_ev(1'b0, n + 1, 158, 119, 6);
    push_ev(1'b0, n + 2, 159, 119, 6);
    push_ev(1'b1, n + 9, 0, 0, 0);
    start(158, 119, 4, 2, 6);
    busy_window(n, 4, 2);

    // Bottom-edge clipping and a fully off-screen box
    n = cyc;
    model_box(n, 10, 118, 2, 3, 1, 1'b0);
    start(10, 118, 2, 3, 1);
    busy_window(n, 2, 3);
    n = cyc;
    push_ev(1'b1, n + 1 + 10, 0, 0, 0);
    start(250, 5, 5, 2, 3);
    busy_window(n, 5, 2);

    // go re-asserted mid-draw with another origin must be ignored
    n = cyc;
    model_box(n, 30, 40, 3, 3, 2, 1'b0);
    start(30, 40, 3, 3, 2);
    x0 = 8'd100;
    y0 = 7'd100;
    go = 1'b1;
    @(negedge clk);
    @(negedge clk);
    go = 1'b0;
    busy_window(n, 3, 3);

    // Reset while drawing a 4x4: three pixels then silence
    n = cyc;
    push_ev(1'b0, n + 1, 50, 50, 3);
    push_ev(1'b0, n + 2, 51, 50, 3);
    push_ev(1'b0, n + 3, 52, 50, 3);
    start(50, 50, 4, 4, 3);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("after_reset", 64'({plot, busy, done}), 64'd0);
    repeat (3) @(negedge clk);
    n = cyc;
    model_box(n, 5, 6, 2, 2, 7, 1'b0);
    start(5, 6, 2, 2, 7);
    busy_window(n, 2, 2);

    // go held high: 1x1 boxes every 3 cycles
    n = cyc;
    push_ev(1'b0, n + 1, 1, 1, 4);
    push_ev(1'b1, n + 2, 0, 0, 0);
    push_ev(1'b0, n + 4, 1, 1, 4);
    push_ev(1'b1, n + 5, 0, 0, 0);
    x0     = 8'd1;
    y0     = 7'd1;
    width  = 5'd1;
    height = 5'd1;
    colour = 3'd4;
    go     = 1'b1;
    repeat (4) @(negedge clk);
    go = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_go_idle", 64'(busy), 64'd0);

`ifdef BOX_DRAWER_OUTLINE_EN
    n = cyc;
    model_box(n, 0, 0, 4, 4, 2, 1'b1);
    outline = 1'b1;
    start(0, 0, 4, 4, 2);
    outline = 1'b0;
    busy_window(n, 4, 4);
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(expq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/box_drawer.md
Name: box_drawer

Overview:
- Downstream pixel engine for the symbol-drawer control FSM; executes one filled rectangle per `go` and signals completion.
- Takes origin, size and colour from the symbol-drawer datapath.
- Emits one pixel per cycle, in raster order, to the VGA adapter write port (x, y, colour, plot).
- Pulses `done` after the last pixel; the controller uses this as its box-done input.

Parameters:
- X_W, 8, x coordinate width (160-pixel screen)
- Y_W, 7, y coordinate width (120-line screen)
- SIZE_W, 5, width/height field width (boxes up to 31x31)
- COLOUR_W, 3, colour width
- SCREEN_W, 160, visible columns; x >= SCREEN_W is clipped
- SCREEN_H, 120, visible rows; y >= SCREEN_H is clipped

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- go  in  1  start request; sampled only in IDLE
- x0  in  X_W  box origin column
- y0  in  Y_W  box origin row
- width  in  SIZE_W  box width in pixels
- height  in  SIZE_W  box height in pixels
- colour  in  COLOUR_W  fill colour
- vga_x  out  X_W  pixel column
- vga_y  out  Y_W  pixel row
- vga_colour  out  COLOUR_W  pixel colour
- plot  out  1  pixel write strobe
- busy  out  1  high in DRAW and DONE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (sync, active-high): state=IDLE; cx, cy, x0_r, y0_r, w_r, h_r, colour_r all 0. Outputs plot=0, done=0, busy=0, vga_x=0, vga_y=0, vga_colour=0.
- States and transitions:
  - IDLE: if `go` at edge N, latch x0/y0/width/height/colour and clear cx, cy. If width==0 or height==0, go to DONE; otherwise go to DRAW.
  - DRAW: one pixel per cycle.
    - vga_x = x0_r+cx, truncated to X_W.
    - vga_y = y0_r+cy, truncated to Y_W.
    - vga_colour = colour_r.
    - If cx==w_r-1: cx<=0, cy<=cy+1; else cx<=cx+1.
    - If cx==w_r-1 and cy==h_r-1: go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency:
  - First pixel is presented in cycle N+1.
  - DRAW lasts exactly w*h cycles.
  - `done` is high in cycle N+1+w*h.
  - `go` may be accepted again in cycle N+2+w*h.
- Clipping:
  - Sums are computed in X_W+1 / Y_W+1 bits.
  - If the x sum >= SCREEN_W or the y sum >= SCREEN_H: plot=0 for that cycle, but the scan still advances. Cycle count is unchanged.
- Output decode: plot = (state==DRAW) && on-screen. vga_* are combinational from registered state and counters. In IDLE and DONE, vga_* hold 0.
- `go` while busy: ignored, no queuing. Inputs may change after the accept edge without effect.
- Reset mid-DRAW: next cycle is IDLE with plot=0, and no `done` pulse is produced.
- `go` held high continuously: a new box starts every w*h+2 cycles.

Optional Feature:
- Macro: BOX_DRAWER_OUTLINE_EN.
- Defined:
  - Adds input port `outline` (1 bit), latched with `go`.
  - When the latched value is 1, plot is additionally gated by (cx==0 || cx==w_r-1 || cy==0 || cy==h_r-1).
  - Scan timing is unchanged.
- Undefined:
  - No `outline` port.
  - Every in-screen pixel is plotted.

Decomposition:
- Shared package draw_pkg holds:
  - X_W, Y_W, SIZE_W, COLOUR_W, SCREEN_W, SCREEN_H
  - the box_drawer state enum (IDLE, DRAW, DONE)
- The same widths are reused by the symbol-drawer datapath.
- One sub-module, box_scan_counter: the cx/cy raster counter with clear, enable, w/h limits and a `last` flag. The FSM, clipping and output decode stay in box_drawer.

Test Plan:
- go at (x0=10, y0=20), w=2, h=3, colour=3'b101 -> 6 plots in cycles 1..6, in order (10,20),(11,20),(10,21),(11,21),(10,22),(11,22); done=1 only in cycle 7; busy cycles 1..7.
- w=0, h=5 -> no plot; done in cycle 1; IDLE in cycle 2.
- x0=158, y0=119, w=4, h=2 -> plot only at (158,119) and (159,119); done still in cycle 9.
- go re-asserted during DRAW of a 3x3 box with a different origin -> ignored; exactly 9 plots, all at the original origin.
- Reset asserted in cycle 3 of a 4x4 box -> cycle 4 shows plot=0, busy=0, done=0; a new go draws from cx=cy=0.
- With BOX_DRAWER_OUTLINE_EN, outline=1, 4x4 at (0,0) -> 12 plots (border only) over 16 DRAW cycles; done in cycle 17.
